sibling_relay_stage: RTL and testbench
======================================

# sibling_relay_stage

Token relay stage placed between adjacent sibling instances of a generated hierarchy level (inst_N feeds inst_N+1). It accepts tokens from the upstream sibling over a valid/ready link and buffers them in a 4-entry FIFO. Each forwarded token has its hop count incremented and carries this stage's ID. Expired tokens are retired locally and counted, so a chain of these stages forms a bounded-latency ring between siblings.

## Interface
- DATA_W, 16, token payload width
- HOP_W, 4, hop-count width; HOP_MAX = 2**HOP_W-1
- STAGE_ID, 0, this stage's ID, 0..7
- DEPTH, 4, FIFO entries, power of two, ≥2
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream token present
- in_ready  out  1  stage can accept token
- in_data  in  DATA_W  upstream payload
- in_hops  in  HOP_W  upstream hop count
- out_valid  out  1  token available downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload, unmodified
- out_hops  out  HOP_W  in_hops+1 of the head token
- out_src  out  3  STAGE_ID of the forwarding stage
- pass_count  out  16  tokens forwarded, wraps at 2^16
- drop_count  out  8  expired tokens retired, saturates at 255

## Operation
- Push on in_valid && in_ready. Pop on out_valid && out_ready.
- in_ready = !full. It is registered state only, with no combinational path from out_ready.
- Expiry check at push: if in_hops == HOP_MAX, the token is accepted (handshake completes) but not written to the FIFO.
  - drop_count increments, saturating at 255.
  - pass_count is unchanged.
- Non-expired tokens are stored as {data, hops+1}. The increment cannot overflow because HOP_MAX tokens never enter the FIFO.
- out_src is the constant STAGE_ID.
- pass_count increments on every pop and wraps modulo 2^16.
- FIFO: read/write pointers of log2(DEPTH)+1 bits.
  - empty when the pointers are equal.
  - full when the MSBs differ and the rest of the bits are equal.
  - Pointers wrap naturally.
- Simultaneous push and pop:
  - when full: push is blocked (in_ready=0) and pop proceeds; in_ready rises the next cycle.
  - when empty: the pushed token is not visible this cycle; it appears the next cycle.
  - otherwise: occupancy is unchanged and both pointers advance.
- An expired push coinciding with a pop changes occupancy by -1 only.
- out_valid = !empty. The head entry is held stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release) forces these values:
  - in_ready=0 during reset, 1 from the first cycle after deassert.
  - out_valid=0, out_data=0, out_hops=0.
  - pass_count=0, drop_count=0.
  - Pointers are 0.
- Latency is exactly 1 cycle: a token pushed at edge k is presented on out_* after edge k when the FIFO was empty.
- Throughput is 1 token/cycle sustained while out_ready=1.
- Reset mid-operation: all buffered tokens are discarded and both counters clear immediately, asynchronously. No partial token is emitted after release.
- Counter updates become visible the cycle after the handshake edge.

## Structure
- Package relay_pkg contains:
  - typedef token_t packed {logic [DATA_W-1:0] data; logic [HOP_W-1:0] hops;}
  - localparam HOP_MAX
  - localparam SRC_W=3
- Sub-module relay_fifo (parameterised on width and DEPTH) provides push/pop/full/empty and a registered head output.
- The top level adds expiry logic, the hop increment and the counters.

## Test plan
- Reset release, then in_valid=1, data=0xA5A5, hops=2, out_ready=1 → next cycle out_valid=1, out_data=0xA5A5, out_hops=3, out_src=STAGE_ID; pass_count=1 one cycle after the pop.
- out_ready=0, push 5 tokens on consecutive cycles → in_ready drops after the 4th; the 5th is held upstream. Raise out_ready → tokens emerge in order, in_ready returns the cycle after the first pop.
- Push a token with hops=15 (HOP_W=4) → handshake completes, out_valid stays 0, drop_count=1, pass_count unchanged. Repeat 300 times → drop_count stays at 255.
- FIFO full with in_valid=1 and out_ready=1 for 10 cycles → no loss, no duplication, and the sequence is preserved across pointer wrap.
- Forward 65537 tokens → pass_count reads 1.
- Fill 3 entries, then pulse rst_n low mid-cycle → out_valid, counters and out_data go to 0 immediately; the first output after release is a newly pushed token.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types and constants for the sibling token relay.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Token widths are fixed here so every sibling in the generated level
// agrees on the link format without per-instance parameter plumbing.
package relay_pkg;

  localparam int DATA_W  = 16;
  localparam int HOP_W   = 4;
  localparam int HOP_MAX = 2**HOP_W - 1;
  localparam int SRC_W   = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [HOP_W-1:0]  hops;
  } token_t;

  localparam int TOKEN_W = $bits(token_t);

endpackage

// File: rtl/relay_fifo.sv
// Generic register-based FIFO with push/pop strobes and a head output.
// Latency: a pushed word is visible at o_head the cycle after the push edge.
// Backpressure: caller must not push when o_full nor pop when o_empty.
//
// Ports:
//   clk, rst_n        clock and async active-low reset
//   i_push/i_push_dat write strobe and word
//   i_pop             read strobe (advances head)
//   o_full/o_empty    occupancy flags, derived from registered pointers
//   o_head            word at the read pointer, sourced from storage registers
module relay_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      // Storage is cleared so the head reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/sibling_relay_stage.sv
// Relays tokens between adjacent siblings, bumping hop count and retiring expired tokens.
// Latency: 1 cycle from accept to presentation on out_* when the buffer is empty.
// Backpressure: in_ready = !full from registered state only; no path from out_ready.
//
// Ports:
//   clk, rst_n                      clock and async active-low reset
//   in_valid/in_ready/in_data/in_hops   upstream token link
//   out_valid/out_ready/out_data/out_hops/out_src   downstream token link
//   pass_count                      forwarded tokens, wraps at 2^16
//   drop_count                      expired tokens retired, saturates at 255
module sibling_relay_stage
  import relay_pkg::*;
#(
  parameter int STAGE_ID = 0,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [HOP_W-1:0]  in_hops,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [HOP_W-1:0]  out_hops,
  output logic [SRC_W-1:0]  out_src,
  output logic [15:0]       pass_count,
  output logic [7:0]        drop_count
);

  logic        r_ready_en;
  logic [15:0] r_pass_cnt;
  logic [7:0]  r_drop_cnt;

  logic   w_full;
  logic   w_empty;
  logic   w_accept;
  logic   w_expired;
  logic   w_fifo_push;
  logic   w_pop;
  token_t w_wr_tok;
  token_t w_head;

  // Holds in_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  assign in_ready  = r_ready_en && !w_full;
  assign out_valid = !w_empty;

  assign w_accept    = in_valid && in_ready;
  assign w_expired   = (in_hops == HOP_W'(HOP_MAX));
  // Expired tokens complete the handshake but never occupy a slot.
  assign w_fifo_push = w_accept && !w_expired;
  assign w_pop       = out_valid && out_ready;

  // Cannot overflow: HOP_MAX tokens are filtered before this point.
  assign w_wr_tok.data = in_data;
  assign w_wr_tok.hops = in_hops + HOP_W'(1);

  relay_fifo #(
    .WIDTH (TOKEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_fifo_push),
    .i_push_dat (w_wr_tok),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_pass_cnt <= r_pass_cnt + 16'd1;
      end
      if (w_accept && w_expired && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign out_data   = w_head.data;
  assign out_hops   = w_head.hops;
  assign out_src    = SRC_W'(STAGE_ID);
  assign pass_count = r_pass_cnt;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_sibling_relay_stage.sv
// Directed bench for sibling_relay_stage with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// A small queue model tracks order during the sustained full-traffic phase.
module tb_sibling_relay_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_hops;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_hops;
  logic [2:0]  out_src;
  logic [15:0] pass_count;
  logic [7:0]  drop_count;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] q[$];
  logic [15:0] nxt;
  logic [15:0] exp_pass;

  sibling_relay_stage #(
    .STAGE_ID (5),
    .DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_hops    (in_hops),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_hops   (out_hops),
    .out_src    (out_src),
    .pass_count (pass_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of the queue model: predict flags/head, then advance.
  task automatic step_sb();
    logic p;
    logic o;
    chk("sb_in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 4)});
    chk("sb_out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      chk("sb_head_data", {16'd0, out_data}, {16'd0, q[0]});
      chk("sb_head_hops", {28'd0, out_hops}, 32'd2);
    end
    p = in_valid && (q.size() < 4);
    o = (q.size() != 0) && out_ready;
    if (o) begin
      void'(q.pop_front());
      exp_pass = exp_pass + 16'd1;
    end
    if (p) q.push_back(in_data);
    tick();
    if (p) begin
      nxt     = nxt + 16'd1;
      in_data = nxt;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_hops   = '0;
    out_ready = 1'b0;
    nxt       = '0;
    exp_pass  = '0;

    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_hops", {28'd0, out_hops}, 32'd0);
    chk("rst_pass", {16'd0, pass_count}, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    tick();
    chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Single token, 1-cycle latency
    in_valid = 1'b1; in_data = 16'hA5A5; in_hops = 4'd2; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", {16'd0, out_data}, 32'h0000A5A5);
    chk("t1_out_hops", {28'd0, out_hops}, 32'd3);
    chk("t1_out_src", {29'd0, out_src}, 32'd5);
    chk("t1_pass_before", {16'd0, pass_count}, 32'd0);
    tick();
    chk("t1_pass_after", {16'd0, pass_count}, 32'd1);
    chk("t1_empty", {31'd0, out_valid}, 32'd0);

    // Fill to full with downstream stalled
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'h0100 + 16'(i); in_hops = 4'(i);
      tick();
    end
    chk("t2_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_head_data", {16'd0, out_data}, 32'h00000100);
    chk("t2_head_hops", {28'd0, out_hops}, 32'd1);
    in_data = 16'h0104; in_hops = 4'd4;
    tick();
    chk("t2_held_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_held_head", {16'd0, out_data}, 32'h00000100);
    out_ready = 1'b1;
    tick();
    chk("t2_ready_back", {31'd0, in_ready}, 32'd1);
    chk("t2_head_101", {16'd0, out_data}, 32'h00000101);
    chk("t2_pass2", {16'd0, pass_count}, 32'd2);
    tick();
    in_valid = 1'b0;
    chk("t2_head_102", {16'd0, out_data}, 32'h00000102);
    chk("t2_hops_102", {28'd0, out_hops}, 32'd3);
    tick();
    chk("t2_head_103", {16'd0, out_data}, 32'h00000103);
    tick();
    chk("t2_head_104", {16'd0, out_data}, 32'h00000104);
    chk("t2_hops_104", {28'd0, out_hops}, 32'd5);
    tick();
    chk("t2_drained", {31'd0, out_valid}, 32'd0);
    chk("t2_pass6", {16'd0, pass_count}, 32'd6);

    // Expired tokens and drop saturation
    in_valid = 1'b1; in_data = 16'hBEEF; in_hops = 4'd15;
    chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_no_out", {31'd0, out_valid}, 32'd0);
    chk("t3_drop1", {24'd0, drop_count}, 32'd1);
    chk("t3_pass", {16'd0, pass_count}, 32'd6);
    in_valid = 1'b1;
    repeat (253) tick();
    chk("t3_drop254", {24'd0, drop_count}, 32'd254);
    repeat (47) tick();
    in_valid = 1'b0;
    chk("t3_drop_sat", {24'd0, drop_count}, 32'd255);
    chk("t3_no_out2", {31'd0, out_valid}, 32'd0);

    // Expired push coinciding with a pop: occupancy drops by one
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0AAA; in_hops = 4'd7;
    tick();
    in_hops = 4'd15; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t3b_empty", {31'd0, out_valid}, 32'd0);
    chk("t3b_pass", {16'd0, pass_count}, 32'd7);
    chk("t3b_drop", {24'd0, drop_count}, 32'd255);

    // Full buffer under sustained traffic, across pointer wrap
    exp_pass = 16'd7;
    out_ready = 1'b0; in_hops = 4'd1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'h0200 + 16'(i);
      q.push_back(in_data);
      tick();
    end
    in_valid = 1'b1; out_ready = 1'b1;
    nxt = 16'h0204; in_data = nxt;
    for (int k = 0; k < 10; k++) step_sb();
    in_valid = 1'b0;
    for (int k = 0; k < 8 && q.size() != 0; k++) step_sb();
    chk("t4_drained", {31'd0, out_valid}, 32'd0);
    chk("t4_pass", {16'd0, pass_count}, {16'd0, exp_pass});

    // Asynchronous reset with three tokens buffered
    out_ready = 1'b0; in_hops = 4'd0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h0300 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid0", {31'd0, out_valid}, 32'd0);
    chk("t6_data0", {16'd0, out_data}, 32'd0);
    chk("t6_hops0", {28'd0, out_hops}, 32'd0);
    chk("t6_pass0", {16'd0, pass_count}, 32'd0);
    chk("t6_drop0", {24'd0, drop_count}, 32'd0);
    chk("t6_in_ready0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t6_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_rel_empty", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = 16'h0777; in_hops = 4'd0;
    tick();
    in_valid = 1'b0;
    chk("t6_new_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_new_data", {16'd0, out_data}, 32'h00000777);
    chk("t6_new_hops", {28'd0, out_hops}, 32'd1);

    // Pass counter wrap: 65537 tokens from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 16'h1234; in_hops = 4'd0; out_ready = 1'b1;
    repeat (65537) tick();
    in_valid = 1'b0;
    chk("t5_wrap0", {16'd0, pass_count}, 32'd0);
    chk("t5_last_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("t5_wrap1", {16'd0, pass_count}, 32'd1);
    chk("t5_empty", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
